// File: rtl/catch_score_ctl.sv
// catch_score_ctl: per-frame catch/miss judge for the falling-bag game.
// Samples the player and bag positions on the vblnk rising edge. Keeps a
// saturating 4-digit BCD score and a lives counter, asks bag_ctl to respawn
// the bag, and flags game over.
module catch_score_ctl #(
    parameter int PLAYER_W   = 128,
    parameter int BAG_W      = 64,
    parameter int BAG_H      = 32,
    parameter int FLOOR_Y    = 600,
    parameter int RESPAWN_Y  = 64,
    parameter int LIVES_INIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vblnk,
    input  logic        start,
    input  logic [11:0] player_xpos,
    input  logic [11:0] player_ypos,
    input  logic [11:0] bag_xpos,
    input  logic [11:0] bag_ypos,
    output logic [15:0] score_bcd,
    output logic [1:0]  lives,
    output logic        catch_pulse,
    output logic        miss_pulse,
    output logic        respawn_req,
    output logic        game_over
);

    localparam logic [1:0] ST_PLAY         = 2'd0;
    localparam logic [1:0] ST_WAIT_RESPAWN = 2'd1;
    localparam logic [1:0] ST_GAME_OVER    = 2'd2;

    logic [1:0]  state;
    logic        vblnk_q;
    logic        vblnk_armed;
    logic        start_q;
    logic        tick;
    logic        start_rise;
    logic [12:0] px, py, bx, by;
    logic        hit_x, hit_y, catch_hit, miss_hit, respawned;

    // Saturating BCD +1: ripple carry through the digits, 9999 holds.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v == 16'h9999) return v;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Edge detectors for vblnk (frame tick) and start (restart request).
    // vblnk_armed stays low after reset until vblnk has been seen low, so a
    // vblnk that is already high when reset drops does not count as a tick.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            vblnk_q     <= 1'b0;
            vblnk_armed <= 1'b0;
            start_q     <= 1'b0;
        end else begin
            vblnk_q <= vblnk;
            start_q <= start;
            if (!vblnk) vblnk_armed <= 1'b1;
        end
    end

    assign tick       = vblnk & ~vblnk_q & vblnk_armed;
    assign start_rise = start & ~start_q;

    // Overlap tests in 13 bits so x+W and y+H cannot wrap.
    assign px = {1'b0, player_xpos};
    assign py = {1'b0, player_ypos};
    assign bx = {1'b0, bag_xpos};
    assign by = {1'b0, bag_ypos};

    assign hit_x     = (bx + 13'(BAG_W) > px) && (bx < px + 13'(PLAYER_W));
    assign hit_y     = (by + 13'(BAG_H) >= py) && (by < py);
    assign catch_hit = hit_x && hit_y;
    assign miss_hit  = by >= 13'(FLOOR_Y);
    assign respawned = by < 13'(RESPAWN_Y);

    // Game FSM with registered score, lives, pulses and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_PLAY;
            score_bcd   <= 16'h0000;
            lives       <= 2'(LIVES_INIT);
            catch_pulse <= 1'b0;
            miss_pulse  <= 1'b0;
            respawn_req <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            catch_pulse <= 1'b0;
            miss_pulse  <= 1'b0;
            case (state)
                ST_PLAY: begin
                    if (tick) begin
                        if (catch_hit) begin
                            // A catch wins over a simultaneous floor hit.
                            score_bcd   <= bcd_inc(score_bcd);
                            catch_pulse <= 1'b1;
                            respawn_req <= 1'b1;
                            state       <= ST_WAIT_RESPAWN;
                        end else if (miss_hit) begin
                            miss_pulse  <= 1'b1;
                            respawn_req <= 1'b1;
                            if (lives == 2'd1) begin
                                lives     <= 2'd0;
                                game_over <= 1'b1;
                                state     <= ST_GAME_OVER;
                            end else begin
                                lives <= lives - 2'd1;
                                state <= ST_WAIT_RESPAWN;
                            end
                        end
                    end
                end
                ST_WAIT_RESPAWN: begin
                    // Detection stays off until bag_ctl has moved the bag up top.
                    if (tick && respawned) begin
                        respawn_req <= 1'b0;
                        state       <= ST_PLAY;
                    end
                end
                ST_GAME_OVER: begin
                    // Bag stays parked (respawn_req held) until the player restarts.
                    if (start_rise) begin
                        score_bcd <= 16'h0000;
                        lives     <= 2'(LIVES_INIT);
                        game_over <= 1'b0;
                        state     <= ST_WAIT_RESPAWN;
                    end
                end
                default: state <= ST_PLAY;
            endcase
        end
    end

endmodule

// File: tb/tb_catch_score_ctl.sv
// Directed self-checking bench for catch_score_ctl.
module tb_catch_score_ctl;

    logic        clk;
    logic        rst;
    logic        vblnk;
    logic        start;
    logic [11:0] player_xpos;
    logic [11:0] player_ypos;
    logic [11:0] bag_xpos;
    logic [11:0] bag_ypos;
    logic [15:0] score_bcd;
    logic [1:0]  lives;
    logic        catch_pulse;
    logic        miss_pulse;
    logic        respawn_req;
    logic        game_over;

    int checks   = 0;
    int failures = 0;

    catch_score_ctl u_dut (
        .clk         (clk),
        .rst         (rst),
        .vblnk       (vblnk),
        .start       (start),
        .player_xpos (player_xpos),
        .player_ypos (player_ypos),
        .bag_xpos    (bag_xpos),
        .bag_ypos    (bag_ypos),
        .score_bcd   (score_bcd),
        .lives       (lives),
        .catch_pulse (catch_pulse),
        .miss_pulse  (miss_pulse),
        .respawn_req (respawn_req),
        .game_over   (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent decimal -> BCD model for expected scores.
    function automatic logic [15:0] to_bcd(input int n);
        return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
    endfunction

    // One frame: raise vblnk with the given bag position, sample the pulses
    // right after the update edge, then drop vblnk for one cycle.
    task automatic do_frame(input logic [11:0] bx, input logic [11:0] by,
                            output logic cp, output logic mp);
        @(negedge clk);
        bag_xpos = bx;
        bag_ypos = by;
        vblnk    = 1'b1;
        @(posedge clk); #1;
        cp = catch_pulse;
        mp = miss_pulse;
        @(negedge clk);
        vblnk = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; vblnk = 1'b0; start = 1'b0;
        player_xpos = 12'd400; player_ypos = 12'd450;
        bag_xpos = 12'd420; bag_ypos = 12'd10;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({score_bcd, lives, catch_pulse, miss_pulse, respawn_req, game_over} !== {16'h0000, 2'd3, 4'b0000}) begin
            failures++;
            $display("FAIL reset_values score=%h lives=%0d cp=%b mp=%b rr=%b go=%b required 0000/3/0/0/0/0",
                     score_bcd, lives, catch_pulse, miss_pulse, respawn_req, game_over);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_catch;
        logic cp, mp;
        do_frame(12'd420, 12'd430, cp, mp);
        checks++;
        if (cp !== 1'b1 || mp !== 1'b0) begin
            failures++;
            $display("FAIL catch_pulse cp=%b mp=%b required cp=1 mp=0", cp, mp);
        end
        checks++;
        if (catch_pulse !== 1'b0) begin
            failures++;
            $display("FAIL catch_pulse_width cp=%b required 0 one cycle later", catch_pulse);
        end
        checks++;
        if (score_bcd !== 16'h0001 || respawn_req !== 1'b1) begin
            failures++;
            $display("FAIL catch_score score=%h rr=%b required 0001/1", score_bcd, respawn_req);
        end
        // While waiting, a bag still at catch height must not score again.
        do_frame(12'd420, 12'd430, cp, mp);
        checks++;
        if (cp !== 1'b0 || score_bcd !== 16'h0001 || respawn_req !== 1'b1) begin
            failures++;
            $display("FAIL wait_no_detect cp=%b score=%h rr=%b required 0/0001/1", cp, score_bcd, respawn_req);
        end
        do_frame(12'd420, 12'd10, cp, mp);
        checks++;
        if (respawn_req !== 1'b0) begin
            failures++;
            $display("FAIL respawn_clear rr=%b required 0", respawn_req);
        end
    endtask

    task automatic test_bcd;
        logic cp, mp;
        for (int n = 2; n <= 9999; n++) begin
            do_frame(12'd420, 12'd430, cp, mp);
            checks++;
            if (cp !== 1'b1) begin
                failures++;
                $display("FAIL bcd_catch_pulse n=%0d cp=%b required 1", n, cp);
            end
            if (n == 10 || n == 99 || n == 100 || n == 1000 || n == 9999) begin
                checks++;
                if (score_bcd !== to_bcd(n)) begin
                    failures++;
                    $display("FAIL bcd_score n=%0d score=%h required %h", n, score_bcd, to_bcd(n));
                end
            end
            do_frame(12'd420, 12'd10, cp, mp);
        end
        do_frame(12'd420, 12'd430, cp, mp);
        checks++;
        if (cp !== 1'b1 || score_bcd !== 16'h9999) begin
            failures++;
            $display("FAIL bcd_saturate cp=%b score=%h required 1/9999", cp, score_bcd);
        end
        do_frame(12'd420, 12'd10, cp, mp);
    endtask

    task automatic test_priority;
        logic cp, mp;
        // Bag touches the player and sits on the floor in the same frame.
        player_ypos = 12'd620;
        do_frame(12'd420, 12'd600, cp, mp);
        checks++;
        if (cp !== 1'b1 || mp !== 1'b0 || lives !== 2'd3 || respawn_req !== 1'b1) begin
            failures++;
            $display("FAIL catch_priority cp=%b mp=%b lives=%0d rr=%b required 1/0/3/1", cp, mp, lives, respawn_req);
        end
        player_ypos = 12'd450;
        do_frame(12'd420, 12'd10, cp, mp);
    endtask

    task automatic test_start_in_play;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (score_bcd !== 16'h9999 || lives !== 2'd3 || game_over !== 1'b0) begin
            failures++;
            $display("FAIL start_in_play score=%h lives=%0d go=%b required 9999/3/0", score_bcd, lives, game_over);
        end
        @(negedge clk); start = 1'b0;
    endtask

    task automatic test_miss;
        logic cp, mp;
        logic [1:0] exp_lives;
        exp_lives = 2'd3;
        for (int k = 0; k < 3; k++) begin
            do_frame(12'd0, 12'd600, cp, mp);
            exp_lives = exp_lives - 2'd1;
            checks++;
            if (mp !== 1'b1 || cp !== 1'b0 || lives !== exp_lives || respawn_req !== 1'b1) begin
                failures++;
                $display("FAIL miss_step k=%0d mp=%b cp=%b lives=%0d rr=%b required 1/0/%0d/1",
                         k, mp, cp, lives, respawn_req, exp_lives);
            end
            checks++;
            if (game_over !== (k == 2)) begin
                failures++;
                $display("FAIL miss_game_over k=%0d go=%b required %b", k, game_over, (k == 2));
            end
            if (k < 2) do_frame(12'd0, 12'd10, cp, mp);
        end
    endtask

    task automatic test_game_over_frozen;
        logic cp, mp;
        do_frame(12'd420, 12'd430, cp, mp);
        do_frame(12'd0, 12'd10, cp, mp);
        checks++;
        if (cp !== 1'b0 || score_bcd !== 16'h9999 || lives !== 2'd0 || game_over !== 1'b1 || respawn_req !== 1'b1) begin
            failures++;
            $display("FAIL over_frozen cp=%b score=%h lives=%0d go=%b rr=%b required 0/9999/0/1/1",
                     cp, score_bcd, lives, game_over, respawn_req);
        end
    endtask

    task automatic test_restart;
        logic cp, mp;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (score_bcd !== 16'h0000 || lives !== 2'd3 || game_over !== 1'b0 || respawn_req !== 1'b1) begin
            failures++;
            $display("FAIL restart score=%h lives=%0d go=%b rr=%b required 0000/3/0/1",
                     score_bcd, lives, game_over, respawn_req);
        end
        @(negedge clk); start = 1'b0;
        do_frame(12'd420, 12'd430, cp, mp);
        checks++;
        if (cp !== 1'b0 || score_bcd !== 16'h0000) begin
            failures++;
            $display("FAIL restart_wait cp=%b score=%h required 0/0000", cp, score_bcd);
        end
        do_frame(12'd420, 12'd10, cp, mp);
        checks++;
        if (respawn_req !== 1'b0) begin
            failures++;
            $display("FAIL restart_respawn rr=%b required 0", respawn_req);
        end
        do_frame(12'd420, 12'd430, cp, mp);
        checks++;
        if (cp !== 1'b1 || score_bcd !== 16'h0001) begin
            failures++;
            $display("FAIL restart_catch cp=%b score=%h required 1/0001", cp, score_bcd);
        end
    endtask

    task automatic test_reset_mid;
        logic cp, mp;
        // Now in WAIT_RESPAWN with score 1; raise vblnk and reset mid-cycle.
        @(negedge clk);
        vblnk = 1'b1;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({score_bcd, lives, catch_pulse, miss_pulse, respawn_req, game_over} !== {16'h0000, 2'd3, 4'b0000}) begin
            failures++;
            $display("FAIL async_reset score=%h lives=%0d cp=%b mp=%b rr=%b go=%b required 0000/3/0/0/0/0",
                     score_bcd, lives, catch_pulse, miss_pulse, respawn_req, game_over);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (catch_pulse !== 1'b0 || score_bcd !== 16'h0000) begin
                failures++;
                $display("FAIL no_tick_after_reset i=%0d cp=%b score=%h required 0/0000", i, catch_pulse, score_bcd);
            end
        end
        @(negedge clk); vblnk = 1'b0;
        do_frame(12'd420, 12'd430, cp, mp);
        checks++;
        if (cp !== 1'b1 || score_bcd !== 16'h0001) begin
            failures++;
            $display("FAIL fresh_edge_tick cp=%b score=%h required 1/0001", cp, score_bcd);
        end
    endtask

    initial begin
        test_reset();
        test_catch();
        test_bcd();
        test_priority();
        test_start_in_play();
        test_miss();
        test_game_over_frozen();
        test_restart();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
